// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

   localparam int REG_W       = 3;
   localparam int STALL_CNT_W = 16;

   localparam logic [REG_W-1:0] REG_ZERO = 3'd0;

   typedef enum logic [1:0] {
      RUN,
      MEM_WAIT,
      ERR
   } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   output logic             hazard
);

   // Writes to r0 are discarded, so a load into r0 never creates a dependency.
   assign hazard = ex_mem_read && (ex_rd != REG_ZERO) &&
                   ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage pipeline: memory handshake with
// timeout, taken-branch flush, load-use bubble and a stall-cycle counter.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [REG_W-1:0]       id_rs,
   input  logic [REG_W-1:0]       id_rt,
   input  logic                   id_uses_rt,
   input  logic                   ex_mem_read,
   input  logic [REG_W-1:0]       ex_rd,
   input  logic                   branch_taken,
   input  logic                   mem_read,
   input  logic                   mem_write,
   input  logic                   mem_ack,
   output logic                   mem_req,
   output logic                   pc_en,
   output logic                   if_id_en,
   output logic                   if_id_flush,
   output logic                   id_ex_en,
   output logic                   id_ex_flush,
   output logic                   ex_mem_en,
   output logic                   mem_wb_flush,
   output logic                   mem_err,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

   state_t     state, state_next, cur_state;
   logic [7:0] wait_cnt, wait_cnt_next;
   logic       load_use;

   load_use_detect u_load_use_detect (
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .hazard      (load_use)
   );

   // While reset is held the outputs behave as in RUN with the live inputs.
   assign cur_state = rst ? RUN : state;

   always_comb begin
      state_next    = cur_state;
      wait_cnt_next = wait_cnt;
      mem_req       = 1'b0;
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_en      = 1'b1;
      id_ex_flush   = 1'b0;
      ex_mem_en     = 1'b1;
      mem_wb_flush  = 1'b0;
      mem_err       = 1'b0;

      case (cur_state)
         RUN, MEM_WAIT: begin
            mem_req = (cur_state == MEM_WAIT) || mem_read || mem_write;
            if (mem_req && !mem_ack) begin
               pc_en        = 1'b0;
               if_id_en     = 1'b0;
               id_ex_en     = 1'b0;
               ex_mem_en    = 1'b0;
               mem_wb_flush = 1'b1;
               if (cur_state == RUN) begin
                  state_next    = MEM_WAIT;
                  wait_cnt_next = 8'd1;
               end else if (wait_cnt == TIMEOUT_CNT) begin
                  state_next = ERR;
               end else begin
                  wait_cnt_next = wait_cnt + 8'd1;
               end
            end else begin
               // Release cycle re-evaluates branch and load-use like RUN.
               state_next    = RUN;
               wait_cnt_next = 8'd0;
               if (branch_taken) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (load_use) begin
                  pc_en       = 1'b0;
                  if_id_en    = 1'b0;
                  id_ex_flush = 1'b1;
               end
            end
         end
         ERR: begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_err   = 1'b1;
         end
         default: begin
            state_next = RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         wait_cnt     <= 8'd0;
         stall_cycles <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
         if (!pc_en && (stall_cycles != {STALL_CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
         end
      end
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the 8-bit five-stage MIPS pipeline. Drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Sequences three hazard sources: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses over a req/ack handshake with a timeout. Also keeps a saturating stall-cycle counter for performance debug.

## Interface
- MEM_TIMEOUT, 15: max cycles spent in MEM_WAIT before declaring error (1..255)
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_rs  in  3  source register rs of the instruction in ID
- id_rt  in  3  source register rt of the instruction in ID
- id_uses_rt  in  1  instruction in ID reads rt
- ex_mem_read  in  1  instruction in EX is a load (ID/EX MemRead)
- ex_rd  in  3  destination register of the instruction in EX
- branch_taken  in  1  branch in EX resolved taken this cycle
- mem_read  in  1  EX/MEM MemRead (instruction in MEM is a load)
- mem_write  in  1  EX/MEM MemWrite
- mem_ack  in  1  data memory completes the access this cycle
- mem_req  out  1  data-memory request
- pc_en  out  1  PC load enable
- if_id_en  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID clear to NOP
- id_ex_en  out  1  ID/EX enable
- id_ex_flush  out  1  ID/EX clear to bubble (all control bits 0)
- ex_mem_en  out  1  EX/MEM enable
- mem_wb_flush  out  1  MEM/WB clear to bubble
- mem_err  out  1  sticky timeout error
- stall_cycles  out  16  saturating count of cycles with pc_en = 0

## Operation
- FSM states: RUN, MEM_WAIT, ERR. Reset state is RUN.
- All enable and flush outputs are combinational from state and inputs. State, timeout counter and stall_cycles are registered.
- Default output in RUN with no hazard: all enables = 1, all flushes = 0, mem_req = 0.
- Memory, RUN state:
  - mem_req = mem_read | mem_write.
  - If mem_req = 1 and mem_ack = 0: freeze the pipeline (pc_en, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_flush = 1) and go to MEM_WAIT with timeout count = 1.
  - If mem_ack = 1 in the same cycle: no stall.
- Memory, MEM_WAIT state:
  - mem_req held at 1. Pipeline frozen as above.
  - If mem_ack = 1: all enables = 1, mem_wb_flush = 0, go to RUN.
  - Else if count == MEM_TIMEOUT: go to ERR.
  - Else count increments.
- ERR state: mem_req = 0, all enables = 0, mem_err = 1. Leaves only via rst.
- Branch, RUN state, no memory stall:
  - branch_taken = 1 gives if_id_flush = 1 and id_ex_flush = 1, with pc_en = 1 (loads target).
  - Overrides load-use, because the dependent instruction is squashed.
- Load-use, RUN state, no memory stall, no branch:
  - Hazard when ex_mem_read = 1, ex_rd != 0, and (ex_rd == id_rs, or id_uses_rt = 1 and ex_rd == id_rt).
  - Response: pc_en = 0, if_id_en = 0, id_ex_flush = 1 for exactly one cycle.
- Priority: ERR > memory stall > branch > load-use.
- Inputs branch_taken and load-use are ignored during MEM_WAIT. They are held by the frozen registers and re-evaluated in the release cycle.
- stall_cycles increments on every cycle with pc_en = 0, including ERR, and saturates at 16'hFFFF.

## Timing
- Reset values: state = RUN, timeout count = 0, stall_cycles = 0, mem_err = 0.
- Outputs during reset follow RUN state with the current inputs.
- rst asserted in MEM_WAIT or ERR: the next cycle is RUN and mem_req drops combinationally unless mem_read or mem_write is still asserted.
- Single-cycle memory (mem_ack together with mem_req): zero stall cycles.
- Memory acked N cycles after the request (N ≥ 1): exactly N stall cycles.
- Timeout: ERR entered on the edge after cycle MEM_TIMEOUT of MEM_WAIT.
- Load-use costs 1 bubble. A taken branch costs 2 flushed slots.
- mem_ack outside a request: ignored.

## Structure
- Package pipe_ctrl_pkg holds:
  - state enum (RUN, MEM_WAIT, ERR)
  - REG_ZERO = 3'd0
  - REG_W = 3, STALL_CNT_W = 16
- Sub-module load_use_detect: combinational comparator producing the hazard flag from ex_mem_read, ex_rd, id_rs, id_rt and id_uses_rt.

## Test plan
- ex_mem_read = 1, ex_rd = 3, id_rs = 3 -> one cycle of pc_en = 0, if_id_en = 0, id_ex_flush = 1; stall_cycles = 1. Repeat with ex_rd = 0 -> no stall.
- branch_taken = 1 with the load-use hazard also present -> if_id_flush = 1, id_ex_flush = 1, pc_en = 1; no load-use stall.
- mem_read = 1, mem_ack arrives 3 cycles later -> mem_req high for 4 cycles; freeze for 3 cycles with mem_wb_flush = 1; release on the ack cycle; stall_cycles = 3.
- mem_write = 1 with mem_ack in the same cycle -> mem_req = 1 for 1 cycle; no stall.
- mem_read = 1, mem_ack never arrives, MEM_TIMEOUT = 15 -> ERR after 15 wait cycles; mem_err = 1; mem_req = 0; rst returns to RUN with stall_cycles = 0.
- branch_taken pulsed during MEM_WAIT -> no flush. With branch_taken still asserted on the release cycle -> flush occurs in that cycle.
